// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: march-style BIST initiator for a dual-port SRAM.
// Writes a background through port A and reads it back through port B.
// It then writes the inverted background through port B (descending) and
// reads it back through port A. The first mismatch is reported.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no test since reset; waiting for start
// INIT     | cycle 0 after start accepted; busy, no SRAM activity
// WR_A     | port A writes d(addr), addr ascending 0..DEPTH-1
// RD_B     | port B reads, addr ascending; compares lag by one cycle
// FLUSH_B  | no enables; last RD_B compare
// WR_B     | port B writes ~d(addr), addr descending DEPTH-1..0
// RD_A     | port A reads, addr descending; compares lag by one cycle
// FLUSH_A  | no enables; last RD_A compare
// DONE     | result held (pass or fail); start restarts the test
module sram_bist_ctrl #(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] PATTERN = 16'hA5A5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              fail_port,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we_a,
  output logic              mem_en_a,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] mem_wdata_a,
  input  logic [DATA_W-1:0] mem_rdata_a,
  output logic              mem_we_b,
  output logic              mem_en_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_wdata_b,
  input  logic [DATA_W-1:0] mem_rdata_b
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_WR_A, ST_RD_B, ST_FLUSH_B,
    ST_WR_B, ST_RD_A, ST_FLUSH_A, ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  // Reads issued last cycle; their data is on rdata this cycle.
  logic              chk_a, chk_b;
  logic [ADDR_W-1:0] chk_addr_a, chk_addr_b;
  logic              mismatch, mismatch_port;
  logic [DATA_W-1:0] mismatch_data;
  logic [ADDR_W-1:0] mismatch_addr;

  logic              accept;
  logic              busy_n, done_n, pass_n, fail_n, fail_port_n;
  logic [ADDR_W-1:0] fail_addr_n;
  logic [DATA_W-1:0] fail_data_n;
  logic              we_a_n, en_a_n, we_b_n, en_b_n;
  logic [ADDR_W-1:0] addr_a_n, addr_b_n;
  logic [DATA_W-1:0] wdata_a_n, wdata_b_n;

  function automatic logic [DATA_W-1:0] pat_of(input logic [ADDR_W-1:0] a);
    return PATTERN ^ DATA_W'(a);
  endfunction

  // Compare returned read data against the expected background.
  always_comb begin
    mismatch      = 1'b0;
    mismatch_port = 1'b0;
    mismatch_addr = '0;
    mismatch_data = '0;
    if (chk_b && (mem_rdata_b != pat_of(chk_addr_b))) begin
      mismatch      = 1'b1;
      mismatch_port = 1'b1;
      mismatch_addr = chk_addr_b;
      mismatch_data = mem_rdata_b;
    end else if (chk_a && (mem_rdata_a != ~pat_of(chk_addr_a))) begin
      mismatch      = 1'b1;
      mismatch_port = 1'b0;
      mismatch_addr = chk_addr_a;
      mismatch_data = mem_rdata_a;
    end
  end

  // Next-state, address counter and next values of all registered outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        state_next = ST_WR_A;
        cnt_next   = '0;
      end
      ST_WR_A: begin
        cnt_next = cnt + ADDR_W'(1);
        if (cnt == ADDR_MAX) state_next = ST_RD_B;
      end
      ST_RD_B: begin
        cnt_next = cnt + ADDR_W'(1);
        if (cnt == ADDR_MAX) state_next = ST_FLUSH_B;
      end
      ST_FLUSH_B: begin
        state_next = ST_WR_B;
        cnt_next   = ADDR_MAX;
      end
      ST_WR_B: begin
        cnt_next = cnt - ADDR_W'(1);
        if (cnt == '0) begin
          state_next = ST_RD_A;
          cnt_next   = ADDR_MAX;
        end
      end
      ST_RD_A: begin
        cnt_next = cnt - ADDR_W'(1);
        if (cnt == '0) state_next = ST_FLUSH_A;
      end
      ST_FLUSH_A: state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
    // A mismatch ends the run immediately; the outstanding read is dropped.
    if (mismatch) state_next = ST_DONE;

    busy_n    = (state_next != ST_IDLE) && (state_next != ST_DONE);
    we_a_n    = (state_next == ST_WR_A);
    en_a_n    = (state_next == ST_RD_A);
    we_b_n    = (state_next == ST_WR_B);
    en_b_n    = (state_next == ST_RD_B);
    addr_a_n  = (we_a_n || en_a_n) ? cnt_next : '0;
    addr_b_n  = (we_b_n || en_b_n) ? cnt_next : '0;
    wdata_a_n = we_a_n ? pat_of(cnt_next) : '0;
    wdata_b_n = we_b_n ? ~pat_of(cnt_next) : '0;

    done_n      = done;
    pass_n      = pass;
    fail_n      = fail;
    fail_port_n = fail_port;
    fail_addr_n = fail_addr;
    fail_data_n = fail_data;
    if (accept) begin
      done_n      = 1'b0;
      pass_n      = 1'b0;
      fail_n      = 1'b0;
      fail_port_n = 1'b0;
      fail_addr_n = '0;
      fail_data_n = '0;
    end else if (mismatch) begin
      done_n      = 1'b1;
      pass_n      = 1'b0;
      fail_n      = 1'b1;
      fail_port_n = mismatch_port;
      fail_addr_n = mismatch_addr;
      fail_data_n = mismatch_data;
    end else if (state == ST_FLUSH_A) begin
      done_n = 1'b1;
      pass_n = 1'b1;
    end
  end

  // State, counter and compare pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      chk_a      <= 1'b0;
      chk_b      <= 1'b0;
      chk_addr_a <= '0;
      chk_addr_b <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      chk_a      <= mem_en_a && !mismatch;
      chk_b      <= mem_en_b && !mismatch;
      chk_addr_a <= mem_addr_a;
      chk_addr_b <= mem_addr_b;
    end
  end

  // Registered outputs: status and both SRAM ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_port   <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      mem_we_a    <= 1'b0;
      mem_en_a    <= 1'b0;
      mem_addr_a  <= '0;
      mem_wdata_a <= '0;
      mem_we_b    <= 1'b0;
      mem_en_b    <= 1'b0;
      mem_addr_b  <= '0;
      mem_wdata_b <= '0;
    end else begin
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      fail        <= fail_n;
      fail_port   <= fail_port_n;
      fail_addr   <= fail_addr_n;
      fail_data   <= fail_data_n;
      mem_we_a    <= we_a_n;
      mem_en_a    <= en_a_n;
      mem_addr_a  <= addr_a_n;
      mem_wdata_a <= wdata_a_n;
      mem_we_b    <= we_b_n;
      mem_en_b    <= en_b_n;
      mem_addr_b  <= addr_b_n;
      mem_wdata_b <= wdata_b_n;
    end
  end

endmodule
